actl_argmax_tracker: RTL and testbench

ACTL_ARGMAX_TRACKER -- requirements
Module: actl_argmax_tracker

---
 rtl/actl_argmax_tracker.sv | 168 ++++++++++++++++
 tb/tb_actl_argmax_tracker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/actl_argmax_tracker.sv
// actl_argmax_tracker: streams P signed activations, N per beat, and reports the
// index of the largest one, both as a binary index and as a one-hot vector.
// The earliest neuron wins ties.
// Optional feature macro ACCURACY_COUNT_EN: when it is defined, the block tracks
// the ideal index from ans_in and drives correct and correct_count. When it is
// not defined, both of those outputs are tied to 0 and ans_in is ignored.
//
// state  | meaning
// IDLE   | no beat of the current sample accepted yet (beat_cnt = 0)
// ACCUM  | part of the sample accepted (0 < beat_cnt < P/N)
// REPORT | one cycle: result registers updated, pred_valid high, in_ready low
module actl_argmax_tracker #(
  parameter int width = 10,
  parameter int N     = 4,
  parameter int P     = 64,
  parameter int CW    = 16,
  localparam int IW    = (P > 1) ? $clog2(P) : 1,
  localparam int BEATS = P / N,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width*N-1:0]   act_in,
  input  logic [N-1:0]         ans_in,
  output logic                 pred_valid,
  output logic [IW-1:0]        pred_idx,
  output logic [P-1:0]         pred_alln,
  output logic                 correct,
  output logic [CW-1:0]        sample_count,
  output logic [CW-1:0]        correct_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

  localparam logic signed [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

  state_t                   state;
  logic [BW-1:0]            beat_cnt;
  logic signed [width-1:0]  run_max;
  logic [IW-1:0]            run_idx;

  logic signed [width-1:0]  bmax;
  logic [LW-1:0]            blane;
  logic [IW-1:0]            cand_idx;
  logic signed [width-1:0]  nxt_max;
  logic [IW-1:0]            nxt_idx;
  logic                     accept;
  logic                     last;

  assign in_ready = (state != S_REPORT);
  assign accept   = in_valid && in_ready && !clear;
  assign last     = accept && (beat_cnt == BW'(BEATS - 1));

  // Largest lane of this beat; a strict compare keeps the lowest lane on ties.
  always_comb begin
    bmax  = $signed(act_in[width-1:0]);
    blane = '0;
    for (int k = 1; k < N; k++) begin
      if ($signed(act_in[width*k +: width]) > bmax) begin
        bmax  = $signed(act_in[width*k +: width]);
        blane = LW'(k);
      end
    end
    cand_idx = IW'(32'(beat_cnt) * N + 32'(blane));
    if (bmax > run_max) begin
      nxt_max = bmax;
      nxt_idx = cand_idx;
    end else begin
      nxt_max = run_max;
      nxt_idx = run_idx;
    end
  end

  // Sequencing FSM with the running maximum and the registered prediction outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      run_max      <= MOST_NEG;
      run_idx      <= '0;
      pred_valid   <= 1'b0;
      pred_idx     <= '0;
      pred_alln    <= '0;
      sample_count <= '0;
    end else if (clear) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      run_max    <= MOST_NEG;
      run_idx    <= '0;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= 1'b0;
      case (state)
        S_REPORT: state <= S_IDLE;
        default: begin
          if (last) begin
            state      <= S_REPORT;
            beat_cnt   <= '0;
            run_max    <= MOST_NEG;
            run_idx    <= '0;
            pred_valid <= 1'b1;
            pred_idx   <= nxt_idx;
            pred_alln  <= P'(1) << nxt_idx;
            if (sample_count != {CW{1'b1}})
              sample_count <= sample_count + CW'(1);
          end else if (accept) begin
            state    <= S_ACCUM;
            beat_cnt <= beat_cnt + BW'(1);
            run_max  <= nxt_max;
            run_idx  <= nxt_idx;
          end
        end
      endcase
    end
  end

`ifdef ACCURACY_COUNT_EN
  logic          ideal_found;
  logic [IW-1:0] ideal_idx;
  logic [LW-1:0] alane;
  logic [IW-1:0] ans_idx;
  logic          fin_found;
  logic [IW-1:0] fin_idx;

  // Lowest set ideal bit of this beat, merged with what earlier beats captured.
  always_comb begin
    alane = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (ans_in[k]) alane = LW'(k);
    end
    ans_idx   = IW'(32'(beat_cnt) * N + 32'(alane));
    fin_found = ideal_found || (|ans_in);
    fin_idx   = ideal_found ? ideal_idx : ans_idx;
  end

  // Ideal index capture plus the accuracy outputs, which update on the REPORT entry edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ideal_found   <= 1'b0;
      ideal_idx     <= '0;
      correct       <= 1'b0;
      correct_count <= '0;
    end else if (clear) begin
      ideal_found <= 1'b0;
      ideal_idx   <= '0;
    end else if (last) begin
      ideal_found <= 1'b0;
      ideal_idx   <= '0;
      correct     <= fin_found && (fin_idx == nxt_idx);
      if (fin_found && (fin_idx == nxt_idx) && (correct_count != {CW{1'b1}}))
        correct_count <= correct_count + CW'(1);
    end else if (accept) begin
      ideal_found <= fin_found;
      ideal_idx   <= fin_idx;
    end
  end
`else
  logic unused_ans;
  assign unused_ans    = ^ans_in;
  assign correct       = 1'b0;
  assign correct_count = '0;
`endif

endmodule

// File: tb/tb_actl_argmax_tracker.sv
// Bench for actl_argmax_tracker (N=4, P=16), with a second CW=2 instance that
// shares the same stimulus so counter saturation can be observed.
module tb_actl_argmax_tracker;
  localparam int W = 10;
  localparam int N = 4;
  localparam int P = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           clear = 1'b0;
  logic           in_valid = 1'b0;
  logic [W*N-1:0] act_in = '0;
  logic [N-1:0]   ans_in = '0;
  logic           in_ready, pred_valid, correct;
  logic [3:0]     pred_idx;
  logic [P-1:0]   pred_alln;
  logic [15:0]    sample_count, correct_count;
  logic           in_ready2, pred_valid2, correct2;
  logic [3:0]     pred_idx2;
  logic [P-1:0]   pred_alln2;
  logic [1:0]     sample_count2, correct_count2;

  actl_argmax_tracker #(.width(W), .N(N), .P(P), .CW(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .ans_in(ans_in), .pred_valid(pred_valid), .pred_idx(pred_idx),
    .pred_alln(pred_alln), .correct(correct), .sample_count(sample_count),
    .correct_count(correct_count));

  actl_argmax_tracker #(.width(W), .N(N), .P(P), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .act_in(act_in), .ans_in(ans_in), .pred_valid(pred_valid2), .pred_idx(pred_idx2),
    .pred_alln(pred_alln2), .correct(correct2), .sample_count(sample_count2),
    .correct_count(correct_count2));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic       cor;
  } exp_t;

  exp_t                  sb[$];
  logic signed [W-1:0]   acts[P];
  logic [P-1:0]          ans;
  int n_cmp = 0;
  int n_fail = 0;
  int exp_samples = 0;
  int exp_correct = 0;
  int pulses = 0;
  int exp_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain argmax over the whole sample, earliest index on ties.
  function automatic exp_t model();
    exp_t e;
    int best;
    int idx;
    int ideal;
    best  = -512;
    idx   = 0;
    ideal = -1;
    for (int i = 0; i < P; i++) begin
      if (int'(acts[i]) > best) begin
        best = int'(acts[i]);
        idx  = i;
      end
      if (ans[i] && ideal < 0) ideal = i;
    end
    e.idx = 4'(idx);
`ifdef ACCURACY_COUNT_EN
    e.cor = (ideal == idx);
`else
    e.cor = 1'b0;
`endif
    return e;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < P; i++) acts[i] = W'(v);
    ans = '0;
  endtask

  task automatic drive_beat(input int b);
    int n;
    for (int k = 0; k < N; k++) act_in[W*k +: W] = acts[b*N + k];
    ans_in   = ans[b*N +: N];
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_sample(input bit hold);
    exp_t e;
    e = model();
    sb.push_back(e);
    exp_samples++;
    exp_pulses++;
    if (e.cor) exp_correct++;
    for (int b = 0; b < P / N; b++) drive_beat(b);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic check_counts();
    check("sample_count", 32'(sample_count), 32'(exp_samples));
    check("correct_count", 32'(correct_count), 32'(exp_correct));
  endtask

  // Scoreboard consumer: each pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (pred_valid === 1'b1) begin
      pulses++;
      check("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pred_idx", 32'(pred_idx), 32'(e.idx));
        check("pred_alln", 32'(pred_alln), 32'(16'd1 << e.idx));
        check("correct", 32'(correct), 32'(e.cor));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_idx", 32'(pred_idx), 32'd0);
    check("rst_pred_alln", 32'(pred_alln), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_counts();
    reset = 1'b1;
    @(negedge clk);

    // Single peak at neuron 9 with matching ideal bit; latency and pulse width.
    fill(-256);
    acts[9] = 10'sd384;
    ans = 16'h0200;
    send_sample(1'b0);
    check("latency_pulse", 32'(pred_valid), 32'd1);
    check("report_not_ready", 32'(in_ready), 32'd0);
    check("alln_9", 32'(pred_alln), 32'h0200);
    check_counts();
    @(negedge clk);
    check("pulse_width", 32'(pred_valid), 32'd0);
    check("hold_idx", 32'(pred_idx), 32'd9);

    // Cross-beat tie between neurons 2 and 13.
    fill(-100);
    acts[2] = 10'sd255;
    acts[13] = 10'sd255;
    ans = 16'h0004;
    send_sample(1'b0);
    check_counts();
    @(negedge clk);

    // In-beat tie between lanes of neurons 5 and 6; ideal is 6 so not correct.
    fill(-100);
    acts[5] = 10'sd200;
    acts[6] = 10'sd200;
    ans = 16'h0040;
    send_sample(1'b0);
    check_counts();
    @(negedge clk);

    // All most-negative, no ideal bit.
    fill(-512);
    send_sample(1'b0);
    check_counts();
    repeat (2) @(negedge clk);

    // Random samples.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < P; i++) acts[i] = W'($urandom_range(0, 1023));
      ans = 16'($urandom_range(0, 65535));
      send_sample(1'b0);
      check_counts();
      @(negedge clk);
    end

    // Clear with a valid beat 2 discards the partial sample and that beat.
    fill(-256);
    acts[3] = 10'sd500;
    acts[10] = 10'sd510;
    ans = 16'h0008;
    drive_beat(0);
    drive_beat(1);
    for (int k = 0; k < N; k++) act_in[W*k +: W] = acts[8 + k];
    clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_in_ready", 32'(in_ready), 32'd1);
    fill(-256);
    acts[7] = 10'sd100;
    ans = 16'h0080;
    send_sample(1'b0);
    check("clear_idx", 32'(pred_idx), 32'd7);
    check_counts();
    @(negedge clk);

    // Reset mid-sample.
    fill(-256);
    acts[1] = 10'sd300;
    drive_beat(0);
    drive_beat(1);
    in_valid = 1'b0;
    reset = 1'b0;
    exp_samples = 0;
    exp_correct = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("inrst_pred_valid", 32'(pred_valid), 32'd0);
      check("inrst_pred_idx", 32'(pred_idx), 32'd0);
      check("inrst_pred_alln", 32'(pred_alln), 32'd0);
      check_counts();
    end
    reset = 1'b1;
    fill(-256);
    acts[11] = 10'sd50;
    ans = 16'h0800;
    send_sample(1'b0);
    check("post_rst_idx", 32'(pred_idx), 32'd11);
    check_counts();
    @(negedge clk);

    // Back-to-back correct samples with in_valid held through REPORT.
    reset = 1'b0;
    exp_samples = 0;
    exp_correct = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 5; s++) begin
      fill(-300);
      acts[3 * s] = 10'sd200;
      ans = 16'd1 << (3 * s);
      send_sample(1'b1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_counts();
    check("sat_sample_count", 32'(sample_count2), 32'd3);
`ifdef ACCURACY_COUNT_EN
    check("sat_correct_count", 32'(correct_count2), 32'd3);
`else
    check("sat_correct_count", 32'(correct_count2), 32'd0);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(pulses), 32'(exp_pulses));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
